// File: rtl/inverse_haar_dwt_if.sv
// Frame-buffer control/read/write bundle between the inverse Haar engine and the arbiter.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; reads return after a fixed latency, writes are always accepted.
interface inverse_haar_dwt_if #(
    parameter int LOG_N = 9
);
    logic                 start;
    logic [3:0]           levels;
    logic                 busy;
    logic                 done;
    logic                 transposing;
    logic                 rd_en;
    logic [2*LOG_N-1:0]   rd_addr;
    logic [7:0]           rd_data;
    logic                 we;
    logic [2*LOG_N-1:0]   wr_addr;
    logic [7:0]           wr_data;

    // Engine side: drives memory traffic and status, receives command and read data.
    modport master (
        input  start, levels, rd_data,
        output busy, done, transposing, rd_en, rd_addr, we, wr_addr, wr_data
    );

    // Arbiter/controller side.
    modport slave (
        output start, levels, rd_data,
        input  busy, done, transposing, rd_en, rd_addr, we, wr_addr, wr_data
    );
endinterface

// File: rtl/inverse_haar_dwt.sv
// In-place multi-level inverse Haar transform over the shared 8-bit frame buffer.
// Latency: per line 2S+READ_LATENCY+1 cycles; per pass 1+S*(2S+READ_LATENCY+1).
// Backpressure: none; fixed-latency reads, writes issued unconditionally one per cycle.
module inverse_haar_dwt #(
    parameter int LOG_N        = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    inverse_haar_dwt_if.master dwt_io
);
    localparam int              CW         = LOG_N + 1;
    localparam int              NPIX       = 1 << LOG_N;
    localparam logic [CW-1:0]   N_FULL     = CW'(NPIX);
    localparam int              DW         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(READ_LATENCY - 1);
    localparam logic [3:0]      LOG_N_L    = 4'(LOG_N);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_DRAIN, S_WRITE, S_NEXT, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         k_q, k_d;
    logic               col_q, col_d;       // 1 = column pass
    logic [CW-1:0]      size_q, size_d;     // S for the current level
    logic [CW-1:0]      line_q, line_d;
    logic [CW-1:0]      idx_q, idx_d;       // element index in READ / WRITE
    logic [DW-1:0]      drain_q, drain_d;

    logic [3:0]         lvl_clamped;
    logic [CW-1:0]      line_inc;
    logic [LOG_N-1:0]   elem, lin;
    logic [2*LOG_N-1:0] cur_addr;

    logic [READ_LATENCY-1:0] vld_q;
    logic [LOG_N-1:0]        pidx_q [READ_LATENCY];
    logic [7:0]              line_buf [NPIX];

    logic [LOG_N-1:0]   m_idx, h_idx;
    logic [7:0]         a_val, h_val, pix;
    logic signed [9:0]  d_val, x_val;

    assign lvl_clamped = (dwt_io.levels > LOG_N_L) ? LOG_N_L : dwt_io.levels;
    assign line_inc    = line_q + CW'(1);
    assign elem        = idx_q[LOG_N-1:0];
    assign lin         = line_q[LOG_N-1:0];
    // Column passes walk down a column: row index is the element, column is the line.
    assign cur_addr    = col_q ? {elem, lin} : {lin, elem};

    // State register and loop counters
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            col_q   <= 1'b0;
            size_q  <= '0;
            line_q  <= '0;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
            size_q  <= size_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and counter sequencing: deepest level first, column pass before row pass
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        col_d   = col_q;
        size_d  = size_q;
        line_d  = line_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (dwt_io.start) begin
                    if (lvl_clamped == 4'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        k_d     = lvl_clamped - 4'd1;
                        col_d   = 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                size_d  = N_FULL >> k_q;
                line_d  = '0;
                idx_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                idx_d = idx_q + CW'(1);
                if (idx_q == size_q - CW'(1)) begin
                    idx_d   = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DRAIN_LAST) begin
                    idx_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + CW'(1);
                if (idx_q == size_q - CW'(1)) begin
                    idx_d   = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                line_d = line_inc;
                if (line_inc < size_q) begin
                    state_d = S_READ;
                end else if (col_q) begin
                    col_d   = 1'b0;
                    state_d = S_SETUP;
                end else if (k_q != 4'd0) begin
                    k_d     = k_q - 4'd1;
                    col_d   = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read-return valid pipeline; cleared on reset so in-flight returns are dropped
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= (state_q == S_READ);
            for (int s = 1; s < READ_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    // Element index delayed to line up with rd_data, then captured into the line buffer
    always_ff @(posedge clock_i) begin
        pidx_q[0] <= elem;
        for (int s = 1; s < READ_LATENCY; s++) begin
            pidx_q[s] <= pidx_q[s-1];
        end
        if (vld_q[READ_LATENCY-1]) begin
            line_buf[pidx_q[READ_LATENCY-1]] <= dwt_io.rd_data;
        end
    end

    // Pair reconstruction: x = a +/- (h - 128), saturated to a pixel
    always_comb begin
        m_idx = idx_q[LOG_N:1];
        h_idx = size_q[LOG_N:1] + m_idx;
        a_val = line_buf[m_idx];
        h_val = line_buf[h_idx];
        d_val = $signed({2'b00, h_val}) - 10'sd128;
        if (idx_q[0]) begin
            x_val = $signed({2'b00, a_val}) - d_val;
        end else begin
            x_val = $signed({2'b00, a_val}) + d_val;
        end
        if (x_val < 10'sd0) begin
            pix = 8'd0;
        end else if (x_val > 10'sd255) begin
            pix = 8'd255;
        end else begin
            pix = x_val[7:0];
        end
    end

    // Outputs decoded from state; IDLE (and therefore reset) drives everything low
    always_comb begin
        dwt_io.busy        = (state_q != S_IDLE);
        dwt_io.done        = (state_q == S_FINISH);
        dwt_io.transposing = col_q && (state_q != S_IDLE) && (state_q != S_FINISH);
        dwt_io.rd_en       = 1'b0;
        dwt_io.rd_addr     = '0;
        dwt_io.we          = 1'b0;
        dwt_io.wr_addr     = '0;
        dwt_io.wr_data     = '0;
        if (state_q == S_READ) begin
            dwt_io.rd_en   = 1'b1;
            dwt_io.rd_addr = cur_addr;
        end
        if (state_q == S_WRITE) begin
            dwt_io.we      = 1'b1;
            dwt_io.wr_addr = cur_addr;
            dwt_io.wr_data = pix;
        end
    end
endmodule
